// File: rtl/mem_sequencer_if.sv
// rtl/mem_sequencer_if.sv - unified handshaked memory port shared by fetch and load/store
interface mem_sequencer_if #(
  parameter int N = 32
);
  logic         mem_req;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [3:0]   mem_be;
  logic         mem_gnt;
  logic         mem_rvalid;
  logic [N-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_sequencer.sv
// rtl/mem_sequencer.sv - steps a single-cycle core one instruction at a time over one memory port
module mem_sequencer #(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_run,
  input  logic [N-1:0]         i_pc,
  input  logic                 i_core_mem_read,
  input  logic                 i_core_mem_write,
  input  logic [2:0]           i_core_fn3,
  input  logic [N-1:0]         i_core_addr,
  input  logic [N-1:0]         i_core_wdata,
  output logic [31:0]          o_instr_out,
  output logic [N-1:0]         o_load_data,
  output logic                 o_core_en,
  output logic                 o_halted,
  output logic                 o_fault,
  mem_sequencer_if.master      bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_F_REQ  = 3'd1;
  localparam logic [2:0] S_F_WAIT = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_D_REQ  = 3'd4;
  localparam logic [2:0] S_D_WAIT = 3'd5;
  localparam logic [2:0] S_EXEC   = 3'd6;
  localparam logic [2:0] S_FAULT  = 3'd7;

  logic [2:0]   r_state;
  logic [31:0]  r_instr;
  logic [N-1:0] r_load_data;
  logic         r_is_load;

  logic         w_pc_ok;
  logic         w_size_byte;
  logic         w_size_half;
  logic         w_misaligned;
  logic [7:0]   w_byte;
  logic [15:0]  w_half;
  logic [N-1:0] w_load_aligned;
  logic [3:0]   w_store_be;
  logic [N-1:0] w_store_data;

  // fn3[1:0] encodes access size; anything wider than a halfword is treated as a word
  assign w_pc_ok      = (i_pc[1:0] == 2'b00);
  assign w_size_byte  = (i_core_fn3[1:0] == 2'b00);
  assign w_size_half  = (i_core_fn3[1:0] == 2'b01);
  assign w_misaligned = (w_size_half & i_core_addr[0]) |
                        (!w_size_byte & !w_size_half & (i_core_addr[1:0] != 2'b00));
  assign w_byte       = bus.mem_rdata[{i_core_addr[1:0], 3'b000} +: 8];
  assign w_half       = bus.mem_rdata[{i_core_addr[1], 4'b0000} +: 16];

  // Select and extend the addressed lane of the returned word for loads
  always_comb begin
    w_load_aligned = bus.mem_rdata;
    case (i_core_fn3)
      3'b000:  w_load_aligned = {{(N-8){w_byte[7]}}, w_byte};
      3'b001:  w_load_aligned = {{(N-16){w_half[15]}}, w_half};
      3'b100:  w_load_aligned = {{(N-8){1'b0}}, w_byte};
      3'b101:  w_load_aligned = {{(N-16){1'b0}}, w_half};
      default: w_load_aligned = bus.mem_rdata;
    endcase
  end

  // Store byte enables and lane-replicated write data
  always_comb begin
    w_store_be   = 4'b1111;
    w_store_data = i_core_wdata;
    if (w_size_byte) begin
      w_store_be   = 4'b0001 << i_core_addr[1:0];
      w_store_data = {4{i_core_wdata[7:0]}};
    end else if (w_size_half) begin
      w_store_be   = 4'b0011 << {i_core_addr[1], 1'b0};
      w_store_data = {2{i_core_wdata[15:0]}};
    end
  end

  // Instruction sequencing; response data is latched only on the accepting rvalid edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_instr     <= 32'h0000_0013;
      r_load_data <= '0;
      r_is_load   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:   if (i_run) r_state <= S_F_REQ;
        S_F_REQ: begin
          if (!w_pc_ok)         r_state <= S_FAULT;
          else if (bus.mem_gnt) r_state <= S_F_WAIT;
        end
        S_F_WAIT: begin
          if (bus.mem_rvalid) begin
            r_instr <= bus.mem_rdata;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (i_core_mem_read || i_core_mem_write) begin
            r_is_load <= i_core_mem_read;
            r_state   <= S_D_REQ;
          end else begin
            r_state   <= S_EXEC;
          end
        end
        S_D_REQ: begin
          if (w_misaligned)     r_state <= S_FAULT;
          else if (bus.mem_gnt) r_state <= S_D_WAIT;
        end
        S_D_WAIT: begin
          if (bus.mem_rvalid) begin
            if (r_is_load) r_load_data <= w_load_aligned;
            r_state <= S_EXEC;
          end
        end
        S_EXEC:   r_state <= i_run ? S_F_REQ : S_IDLE;
        S_FAULT:  r_state <= S_FAULT;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Request fields come from the state and the core's held inputs, never from gnt/rvalid
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = 4'b0000;
    case (r_state)
      S_F_REQ: begin
        if (w_pc_ok) begin
          bus.mem_req  = 1'b1;
          bus.mem_be   = 4'b1111;
          bus.mem_addr = i_pc;
        end
      end
      S_D_REQ: begin
        if (!w_misaligned) begin
          bus.mem_req  = 1'b1;
          bus.mem_addr = {i_core_addr[N-1:2], 2'b00};
          if (r_is_load) begin
            bus.mem_be    = 4'b1111;
          end else begin
            bus.mem_we    = 1'b1;
            bus.mem_be    = w_store_be;
            bus.mem_wdata = w_store_data;
          end
        end
      end
      default: ;
    endcase
  end

  assign o_instr_out = r_instr;
  assign o_load_data = r_load_data;
  assign o_core_en   = (r_state == S_EXEC);
  assign o_fault     = (r_state == S_FAULT);
  assign o_halted    = (r_state == S_IDLE) || (r_state == S_FAULT);

endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Sequencer that shares one unified, handshaked memory port between instruction fetch and load/store traffic of `single_cycle_riscV`, stepping the core one instruction at a time. Per instruction it fetches the word at the core's PC, presents it on `instruction`, then performs the data access the core requests (if any), aligns load data onto `mem_out`, and finally pulses `core_en` so the core commits PC and register-file state. It sits between the core and the memory/bus wrapper and is the core's only path to memory.

## Interface
- `N`, 32: data/address width. Only 32 is supported.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset. 0 resets every register immediately.
- `run`  in  1  1 = keep stepping; 0 = stop after the current instruction.
- `pc`  in  N  core fetch address (core `address`).
- `core_mem_read`, `core_mem_write`  in  1  core data-access request.
- `core_fn3`  in  3  core access size/sign (`fn3`).
- `core_addr`  in  N  data address (core `alu_out`).
- `core_wdata`  in  N  store data (core `rs2_data`).
- `instr_out`  out  32  instruction to core.
- `load_data`  out  N  aligned, extended load data to core `mem_out`.
- `core_en`  out  1  one-cycle commit strobe to core PC/regfile.
- `mem_req`, `mem_we`  out  1  request and write qualifier.
- `mem_addr`  out  N  word-aligned address (bits [1:0] = 0).
- `mem_wdata`  out  N  lane-replicated store data.
- `mem_be`  out  4  byte enables.
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  response (read data or write ack).
- `mem_rdata`  in  N  read data, valid with `mem_rvalid`.
- `halted`  out  1  high in IDLE or FAULT.
- `fault`  out  1  sticky misalignment fault.

## Operation
- States: IDLE, F_REQ, F_WAIT, DECODE, D_REQ, D_WAIT, EXEC, FAULT.
- IDLE: if `run`=1 -> F_REQ.
- F_REQ: `pc`[1:0]≠0 -> FAULT. Otherwise drive `mem_req`=1, `mem_we`=0, `mem_be`=4'b1111, `mem_addr`=`pc`. On `mem_gnt` -> F_WAIT.
- F_WAIT: on `mem_rvalid`, latch `mem_rdata` into `instr_out` -> DECODE.
- DECODE: one settle cycle so the core decodes the new instruction. `core_mem_read` or `core_mem_write` -> D_REQ, else -> EXEC. If both are set, the read wins.
- D_REQ: misaligned access -> FAULT. Misaligned means halfword with addr[0]=1, or word with addr[1:0]≠0. Otherwise `mem_req`=1 with `mem_addr`={addr[31:2],2'b00}.
  - Loads: `mem_we`=0, `mem_be`=1111.
  - SB: `mem_be`=0001<<addr[1:0], wdata byte replicated ×4.
  - SH: `mem_be`=0011<<{addr[1],1'b0}, halfword replicated ×2.
  - SW: `mem_be`=1111, wdata passed unchanged.
  - On `mem_gnt` -> D_WAIT.
- D_WAIT: on `mem_rvalid` -> EXEC. For loads, `load_data` is set from the selected lane: LB (000) sign-extend, LH (001) sign-extend, LW (010) whole word, LBU (100) zero-extend, LHU (101) zero-extend. Other fn3 values load the whole word.
- EXEC: `core_en`=1 for exactly this cycle. Then `run`=1 -> F_REQ, else -> IDLE.
- FAULT: `fault`=1, no requests, `core_en`=0. Left only by reset.
- `mem_addr`/`mem_we`/`mem_be`/`mem_wdata` are held stable whenever `mem_req`=1 until the grant. `mem_req` is never withdrawn before `mem_gnt`.
- Exactly one outstanding transaction. `mem_rvalid` outside F_WAIT/D_WAIT is ignored. `mem_rvalid` in the grant cycle is ignored; the response must come ≥1 cycle after `mem_gnt`.
- `run` is sampled only in IDLE and EXEC. Dropping it mid-instruction completes that instruction.

## Timing
- Reset values: state IDLE, `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0, `core_en`=0, `instr_out`=32'h0000_0013 (NOP), `load_data`=0, `fault`=0, `halted`=1.
- All outputs are registered or decoded from the state register only; there is no combinational path from `mem_gnt`/`mem_rvalid` to outputs.
- Zero-wait memory (gnt in request cycle, rvalid next cycle):
  - non-memory instruction: 4 cycles (F_REQ, F_WAIT, DECODE, EXEC).
  - load/store: 6 cycles.
- Each cycle of `mem_gnt` delay or extra `mem_rvalid` delay adds one cycle.
- `instr_out` and `load_data` change only on the `mem_rvalid` edge that latches them, and hold through EXEC.
- Reset asserted mid-transaction aborts it. The memory side must be reset together with the sequencer.

## Test plan
- Zero-wait ADDI stream, pc=0,4,8: `core_en` pulses every 4th cycle; `mem_addr` 0→4→8; `mem_we`=0.
- SB, core_addr=0x103, wdata=0x0000_00A5: `mem_addr`=0x100, `mem_be`=1000, `mem_wdata`=0xA5A5_A5A5, `mem_we`=1; `core_en` 6 cycles after the fetch request.
- LH, addr=0x202, rdata=0x8001_1234: `load_data`=0xFFFF_8001. LHU at the same address gives 0x0000_8001. LB at addr 0x200 gives 0x0000_0034.
- `mem_gnt` delayed 3 cycles and `mem_rvalid` delayed 2 cycles: request fields stable throughout; a stray `mem_rvalid` in D_REQ is ignored; instruction takes 6+3+1 cycles on the delayed phase.
- LW, addr=0x6: FAULT, `fault`=1, `halted`=1, no `mem_req`, no `core_en`; only reset clears it.
- `run` dropped in F_WAIT: instruction completes (`core_en` pulses once), sequencer enters IDLE with `halted`=1. Asserting reset=0 in D_WAIT returns all outputs to reset values immediately.
